// File: rtl/score_input_ctrl_pkg.sv
// Shared constants and helpers for the score input controller.
package score_input_ctrl_pkg;

  localparam int unsigned NUM_BTN_DEF   = 4;
  localparam int unsigned DB_CYCLES_DEF = 16;
  localparam int unsigned SCORE_W_DEF   = 32;
  localparam int unsigned OUT_W         = 32;
  localparam int unsigned MAX_BTN       = 16;
  localparam int unsigned CNT_W         = 16;

  function automatic logic [4:0] popcount(input logic [MAX_BTN-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_BTN; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/score_input_ctrl_debounce.sv
// One button channel: two-flop synchronizer, debounce counter, stable level
// and a one-cycle press pulse on each debounced rising level.
module btn_debounce
  import score_input_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Toggle on the DB_CYCLES-th consecutive mismatching edge; press pulse
  // is registered alongside so it coincides with the new stable level.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/score_input_ctrl.sv
// Debounced button bank with saturating press score and a lowest-index-first
// press event queue (one pending bit per channel, ack handshake).
module score_input_ctrl
  import score_input_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BTN   = NUM_BTN_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned SCORE_W   = SCORE_W_DEF,
  localparam int unsigned ID_W     = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_BTN-1:0] button,
  input  logic               score_clr,
  input  logic               ack,
  output logic [NUM_BTN-1:0] light,
  output logic               event_valid,
  output logic [ID_W-1:0]    event_id,
  output logic [OUT_W-1:0]   buttonPressed
);

  logic [NUM_BTN-1:0] press;
  logic [MAX_BTN-1:0] press_ext;
  logic [4:0]         press_cnt;
  logic [NUM_BTN-1:0] pend_q, pend_d, ack_mask;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;
  logic               found;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .clr     (clr),
      .btn_i   (button[g]),
      .level_o (light[g]),
      .press_o (press[g])
    );
  end

  always_comb begin
    press_ext              = '0;
    press_ext[NUM_BTN-1:0] = press;
    press_cnt              = popcount(press_ext);
  end

  // Adding at most 16 to a saturated-width value can only overflow into the
  // single extra sum bit, so that bit alone flags saturation.
  always_comb begin
    sum = {1'b0, score_q} + (SCORE_W+1)'(press_cnt);
    if (score_clr) begin
      score_d = SCORE_W'(press_cnt);
    end else if (sum[SCORE_W]) begin
      score_d = '1;
    end else begin
      score_d = sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    event_id = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (pend_q[i] && !found) begin
        event_id = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign event_valid = |pend_q;

  // Set after clear so a press coinciding with its own ack stays pending.
  always_comb begin
    ack_mask = '0;
    if (ack && event_valid) begin
      ack_mask = NUM_BTN'(1) << event_id;
    end
    pend_d = (pend_q & ~ack_mask) | press;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_q  <= '0;
      score_q <= '0;
    end else begin
      pend_q  <= pend_d;
      score_q <= score_d;
    end
  end

  assign buttonPressed = OUT_W'(score_q);

endmodule
